zrle_burst_arbiter: RTL
=======================

// Module: zrle_burst_arbiter
// PURPOSE
//  Shares one ZRLE_DECOMP instance among N_REQ compressed-burst requesters.
//  Grants the decompressor input to one requester for a whole burst (SOP..EOP or BURST_LEN beats).
//  Routes the decompressed output back to that requester.
//  Holds the grant until the decompressor emits its EOP, because the decompressor flushes its state on EOP.
//  Sits between the requester stream mux and ZRLE_DECOMP in the decoder path.
// PARAMETERS
//  N_REQ      4    number of requesters (2..8)
//  BURST_LEN  8    max input beats per burst (decompressor input burst limit)
//  TIMEOUT    64   idle cycles tolerated in DRAIN before abort
// PORTS
//  clk           in   1         clock
//  rst           in   1         synchronous, active-high reset
//  req_valid_i   in   N_REQ     per-requester input beat valid
//  req_data_i    in   64*N_REQ  per-requester data; requester k on bits [64k+63:64k]
//  req_sop_i     in   N_REQ     first beat of burst
//  req_eop_i     in   N_REQ     last beat of burst
//  req_ready_o   out  N_REQ     beat accepted when valid&ready
//  dec_valid_o   out  1         to ZRLE_DECOMP valid_i
//  dec_data_o    out  64        to ZRLE_DECOMP data_i
//  dec_sop_o     out  1         to ZRLE_DECOMP sop_i
//  dec_eop_o     out  1         to ZRLE_DECOMP eop_i
//  dec_ready_i   in   1         from ZRLE_DECOMP ready_o
//  dec_valid_i   in   1         from ZRLE_DECOMP valid_o
//  dec_data_i    in   64        from ZRLE_DECOMP data_o
//  dec_sop_i     in   1         from ZRLE_DECOMP sop_o
//  dec_eop_i     in   1         from ZRLE_DECOMP eop_o
//  dec_ready_o   out  1         to ZRLE_DECOMP ready_i
//  resp_valid_o  out  N_REQ     decompressed beat valid, one-hot to granted requester
//  resp_data_o   out  64        decompressed data, shared by all requesters
//  resp_sop_o    out  1         decompressed SOP
//  resp_eop_o    out  1         decompressed EOP
//  resp_ready_i  in   N_REQ     per-requester response ready
//  grant_id_o    out  3         current/last granted requester
//  busy_o        out  1         state != IDLE
//  err_timeout_o out  1         sticky; DRAIN timeout hit
//  err_orphan_o  out  1         sticky; decompressor output seen in IDLE
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, timer=0, both err flags=0.
//   All outputs are 0 except dec_ready_o=1. Reset mid-burst aborts immediately; the decompressor is not flushed.
//  States: IDLE -> FEED -> DRAIN -> IDLE.
//  IDLE
//   - Eligible requester k: req_valid_i[k] & req_sop_i[k].
//   - Pick the first eligible k searching rr_ptr, rr_ptr+1, ... (mod N_REQ).
//   - Register grant_id=k and beat_cnt=0; go to FEED next cycle. Grant latency: 1 cycle.
//   - No beats are accepted in IDLE: req_ready_o=0.
//   - dec_ready_o=1. Any dec_valid_i is discarded and sets err_orphan_o.
//  FEED
//   - Combinational pass-through, zero latency, for g=grant_id:
//     dec_*_o = req_*_i[g]; req_ready_o[g] = dec_ready_i; other req_ready_o bits = 0.
//   - Each handshake (dec_valid_o & dec_ready_i) increments beat_cnt.
//   - Go to DRAIN when the handshake beat has req_eop_i[g]=1, or beat_cnt reaches BURST_LEN (the beat that makes it BURST_LEN).
//  Response routing (FEED and DRAIN)
//   - resp_valid_o[g] = dec_valid_i; resp_data/sop/eop_o = dec_*_i; dec_ready_o = resp_ready_i[g].
//   - Other resp_valid_o bits are 0.
//  DRAIN
//   - Input side is closed: dec_valid_o=0, all req_ready_o=0.
//   - Exit on dec_valid_i & dec_eop_i, regardless of dec_ready_o, because the decompressor self-clears on EOP.
//   - On exit: rr_ptr = (g+1) mod N_REQ; next state IDLE.
//   - dec_eop_i seen during FEED is routed to the requester but does not end the burst.
//  Timeout
//   - timer counts DRAIN cycles with no resp handshake; it clears on every handshake and on DRAIN entry.
//   - At timer==TIMEOUT-1: set err_timeout_o, rr_ptr=g+1, go to IDLE.
//  Simultaneous events
//   - EOP beat and BURST_LEN beat on the same handshake: single transition to DRAIN.
//   - Eligible requesters in IDLE are arbitrated only by rr_ptr; there are no priorities.
//  Widths
//   - beat_cnt: clog2(BURST_LEN+1) bits.
//   - timer: clog2(TIMEOUT) bits; saturating, no wrap.
//   - rr_ptr: wraps N_REQ-1 -> 0.
// TESTING
//  1. Single burst: req0 sends 8 beats (sop on beat 0, eop on beat 7), dec_ready_i=1.
//     -> FEED lasts 8 handshakes, then DRAIN; resp_valid_o=4'b0001 until dec_eop_i; then IDLE, rr_ptr=1.
//  2. Contention: req0..3 all eligible at rr_ptr=0.
//     -> grants in order 0,1,2,3,0; grant_id_o steps each burst; no overlap between bursts.
//  3. Short burst: req2 sends 3 beats with eop on beat 2.
//     -> DRAIN after the 3rd handshake; dec_valid_o=0 while req2 keeps valid high.
//  4. Backpressure: dec_ready_i low for 5 cycles mid-FEED.
//     -> req_ready_o[g]=0, beat_cnt frozen; resp_ready_i[g]=0 drives dec_ready_o=0.
//  5. Timeout: no dec_valid_i for 64 cycles in DRAIN.
//     -> err_timeout_o=1, state IDLE, next eligible requester granted.
//  6. Orphan / reset: dec_valid_i=1 in IDLE -> err_orphan_o=1.
//     rst=1 mid-FEED -> next cycle all outputs at reset values, rr_ptr=0.

Source files
------------

// File: rtl/zrle_burst_arbiter.sv
// Burst arbiter sharing one ZRLE decompressor among N_REQ requesters, round-robin per burst.
// Latency: 1-cycle grant; input and response paths are zero-latency pass-through once granted.
// Backpressure: dec_ready_i gates the granted requester; resp_ready_i[grant] gates dec_ready_o.
module zrle_burst_arbiter #(
  parameter int N_REQ     = 4,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [64*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_sop_i,
  input  logic [N_REQ-1:0]   req_eop_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               dec_valid_o,
  output logic [63:0]        dec_data_o,
  output logic               dec_sop_o,
  output logic               dec_eop_o,
  input  logic               dec_ready_i,
  input  logic               dec_valid_i,
  input  logic [63:0]        dec_data_i,
  input  logic               dec_sop_i,
  input  logic               dec_eop_i,
  output logic               dec_ready_o,
  output logic [N_REQ-1:0]   resp_valid_o,
  output logic [63:0]        resp_data_o,
  output logic               resp_sop_o,
  output logic               resp_eop_o,
  input  logic [N_REQ-1:0]   resp_ready_i,
  output logic [2:0]         grant_id_o,
  output logic               busy_o,
  output logic               err_timeout_o,
  output logic               err_orphan_o
);

  localparam int GW = $clog2(N_REQ);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t          state;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   gnt;
  logic [BW-1:0]   beat_cnt;
  logic [TW-1:0]   timer;
  logic            err_timeout;
  logic            err_orphan;

  logic [63:0]     req_data_arr [N_REQ];
  logic [2*N_REQ-1:0] elig2;
  logic [N_REQ-1:0] rot;
  logic            found;
  logic [GW-1:0]   off;
  logic [GW:0]     sum;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   gnt_next;
  logic            feed_hs;
  logic            resp_hs;

  // Unpack the flat requester data bus so the granted lane can be indexed directly.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_data_arr[i] = req_data_i[64*i +: 64];
    end
  end

  // Round-robin pick: rotate eligibility so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    elig2 = {2{req_valid_i & req_sop_i}};
    rot   = elig2[rr_ptr +: N_REQ];
    found = |rot;
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = GW'(i);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (GW+1)'(N_REQ)) sum = sum - (GW+1)'(N_REQ);
    pick = sum[GW-1:0];
  end

  assign gnt_next = (gnt == GW'(N_REQ - 1)) ? '0 : gnt + GW'(1);
  assign feed_hs  = (state == FEED) && req_valid_i[gnt] && dec_ready_i;
  assign resp_hs  = dec_valid_i && resp_ready_i[gnt];

  // Burst FSM: grant in IDLE, count input beats in FEED, wait for decompressor EOP or timeout in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gnt         <= '0;
      beat_cnt    <= '0;
      timer       <= '0;
      err_timeout <= 1'b0;
      err_orphan  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dec_valid_i) err_orphan <= 1'b1;
          if (found) begin
            gnt      <= pick;
            beat_cnt <= '0;
            state    <= FEED;
          end
        end
        FEED: begin
          if (feed_hs) begin
            beat_cnt <= beat_cnt + BW'(1);
            // EOP and burst-length limit on the same beat collapse into one transition.
            if (req_eop_i[gnt] || (beat_cnt == BW'(BURST_LEN - 1))) begin
              state <= DRAIN;
              timer <= '0;
            end
          end
        end
        DRAIN: begin
          // Decompressor self-clears on its EOP, so exit even if the requester is stalling it.
          if (dec_valid_i && dec_eop_i) begin
            rr_ptr <= gnt_next;
            state  <= IDLE;
          end else if (resp_hs) begin
            timer <= '0;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            rr_ptr      <= gnt_next;
            state       <= IDLE;
          end else if (timer != '1) begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath steering: input lane of the granted requester in FEED, response routing in FEED and DRAIN.
  always_comb begin
    req_ready_o  = '0;
    dec_valid_o  = 1'b0;
    dec_data_o   = '0;
    dec_sop_o    = 1'b0;
    dec_eop_o    = 1'b0;
    dec_ready_o  = 1'b1;
    resp_valid_o = '0;
    resp_data_o  = '0;
    resp_sop_o   = 1'b0;
    resp_eop_o   = 1'b0;
    if (state == FEED) begin
      dec_valid_o      = req_valid_i[gnt];
      dec_data_o       = req_data_arr[gnt];
      dec_sop_o        = req_sop_i[gnt];
      dec_eop_o        = req_eop_i[gnt];
      req_ready_o[gnt] = dec_ready_i;
    end
    if (state == FEED || state == DRAIN) begin
      resp_valid_o[gnt] = dec_valid_i;
      resp_data_o       = dec_data_i;
      resp_sop_o        = dec_sop_i;
      resp_eop_o        = dec_eop_i;
      dec_ready_o       = resp_ready_i[gnt];
    end
  end

  assign grant_id_o    = 3'(gnt);
  assign busy_o        = (state != IDLE);
  assign err_timeout_o = err_timeout;
  assign err_orphan_o  = err_orphan;

endmodule
